// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus of the shared-multiplier arbiter: issue handshake plus result return.
// Operands are packed per requester, requester i at [32*i +: 32].
interface mul_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_val;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    resp_val;
  logic [63:0]        resp_p;

  modport master (
    output req_val, req_a, req_b,
    input  req_rdy, resp_val, resp_p
  );

  modport slave (
    input  req_val, req_a, req_b,
    output req_rdy, resp_val, resp_p
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one in-order pipelined multiplier among NREQ requesters.
// A tag FIFO remembers who issued each in-flight multiply so commits route back in order.
module mul_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mul_share_arbiter_if.slave     bus,
  output logic [31:0]            mul_intA,
  output logic [31:0]            mul_intB,
  output logic                   mul_val_op,
  input  logic                   mul_oprand_rdy,
  input  logic                   mul_commit,
  input  logic [63:0]            mul_longP,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   err_orphan
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(DEPTH);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW:0]   scan;
  logic           gnt_any;
  logic           full;
  logic           fire;
  logic           pop;

  logic [IDW-1:0] tag_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic [IDW-1:0] head;

  // NOTE: every variable gets a default before the search loop, otherwise a
  // path that never assigns it would infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!gnt_any && bus.req_val[scan[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt     = scan[IDW-1:0];
      end
    end
  end

  // Issue valid is independent of oprand_rdy so the multiplier handshake has no comb loop.
  assign full        = (count == (PW+1)'(DEPTH));
  assign mul_val_op  = gnt_any && !full;
  assign fire        = mul_val_op && mul_oprand_rdy;
  assign bus.req_rdy = fire ? (NREQ'(1) << gnt) : '0;
  assign mul_intA    = gnt_any ? bus.req_a[32*gnt +: 32] : '0;
  assign mul_intB    = gnt_any ? bus.req_b[32*gnt +: 32] : '0;

  assign pop      = mul_commit && (count != '0);
  assign head     = tag_mem[rd_ptr];
  assign inflight = count;

  // NOTE: the tag storage has no reset; occupancy and pointers are cleared, so
  // stale entries are never read, and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fire) tag_mem[wr_ptr] <= gnt;
  end

  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.resp_val <= '0;
      bus.resp_p   <= '0;
      err_orphan   <= 1'b0;
    end else begin
      if (fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      // Push and pop together leave occupancy unchanged.
      unique case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      bus.resp_val <= pop ? (NREQ'(1) << head) : '0;
      if (pop) bus.resp_p <= mul_longP;

      if (mul_commit && count == '0) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter; the bench itself plays the multiplier,
// driving oprand_rdy, commit and longP with hand-computed products.
module tb_mul_share_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] mul_intA;
  logic [31:0] mul_intB;
  logic        mul_val_op;
  logic        mul_oprand_rdy;
  logic        mul_commit;
  logic [63:0] mul_longP;
  logic [3:0]  inflight;
  logic        err_orphan;

  int n_assert = 0;
  int n_fail   = 0;

  mul_share_arbiter_if #(.NREQ(4)) bus ();

  mul_share_arbiter #(.NREQ(4), .DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .mul_intA       (mul_intA),
    .mul_intB       (mul_intB),
    .mul_val_op     (mul_val_op),
    .mul_oprand_rdy (mul_oprand_rdy),
    .mul_commit     (mul_commit),
    .mul_longP      (mul_longP),
    .inflight       (inflight),
    .err_orphan     (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are checked right after step; comb outputs after settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  initial begin
    int g2[5];
    int g3[3];
    g2 = '{0, 1, 2, 3, 0};
    g3 = '{2, 0, 2};

    reset          = 1'b1;
    bus.req_val    = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    mul_oprand_rdy = 1'b0;
    mul_commit     = 1'b0;
    mul_longP      = '0;

    // Reset state
    do_reset();
    settle();
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_resp_val", 64'(bus.resp_val), 64'd0);
    check("rst_resp_p", bus.resp_p, 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
    check("rst_val_op", 64'(mul_val_op), 64'd0);

    // 1: single request 3*5
    set_ops(0, 32'd3, 32'd5);
    bus.req_val    = 4'b0001;
    mul_oprand_rdy = 1'b1;
    settle();
    check("t1_req_rdy", 64'(bus.req_rdy), 64'h1);
    check("t1_intA", 64'(mul_intA), 64'd3);
    check("t1_intB", 64'(mul_intB), 64'd5);
    step();
    bus.req_val = 4'b0000;
    check("t1_inflight1", 64'(inflight), 64'd1);
    mul_commit = 1'b1;
    mul_longP  = 64'd15;
    step();
    mul_commit = 1'b0;
    check("t1_resp_val", 64'(bus.resp_val), 64'h1);
    check("t1_resp_p", bus.resp_p, 64'd15);
    check("t1_inflight0", 64'(inflight), 64'd0);
    step();
    check("t1_resp_pulse", 64'(bus.resp_val), 64'h0);
    check("t1_resp_p_hold", bus.resp_p, 64'd15);

    // 2: all four requesting from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 1), 32'd10);
    bus.req_val    = 4'b1111;
    mul_oprand_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t2_req_rdy", 64'(bus.req_rdy), 64'(4'b0001 << g2[k]));
      check("t2_intA", 64'(mul_intA), 64'(g2[k] + 1));
      step();
    end
    bus.req_val = 4'b0000;
    settle();
    check("t2_inflight5", 64'(inflight), 64'd5);
    mul_commit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mul_longP = 64'(100 + k);
      step();
      check("t2_resp_val", 64'(bus.resp_val), 64'(4'b0001 << g2[k]));
      check("t2_resp_p", bus.resp_p, 64'(100 + k));
    end
    mul_commit = 1'b0;
    check("t2_inflight0", 64'(inflight), 64'd0);

    // 3: req_val=0101 with rr_ptr=1 -> grants 2,0,2
    bus.req_val = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t3_req_rdy", 64'(bus.req_rdy), 64'(4'b0001 << g3[k]));
      step();
    end
    bus.req_val = 4'b0000;
    check("t3_inflight3", 64'(inflight), 64'd3);
    mul_commit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mul_longP = 64'(200 + k);
      step();
      check("t3_resp_val", 64'(bus.resp_val), 64'(4'b0001 << g3[k]));
    end
    mul_commit = 1'b0;

    // 4: multiplier stall with req0 valid, then release: 7*9
    set_ops(0, 32'd7, 32'd9);
    bus.req_val    = 4'b0001;
    mul_oprand_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t4_stall_rdy", 64'(bus.req_rdy), 64'h0);
      check("t4_stall_val_op", 64'(mul_val_op), 64'd1);
      check("t4_stall_intA", 64'(mul_intA), 64'd7);
      check("t4_stall_intB", 64'(mul_intB), 64'd9);
      step();
      check("t4_stall_inflight", 64'(inflight), 64'd0);
    end
    mul_oprand_rdy = 1'b1;
    settle();
    check("t4_go_rdy", 64'(bus.req_rdy), 64'h1);
    step();
    bus.req_val = 4'b0000;
    check("t4_inflight1", 64'(inflight), 64'd1);
    mul_commit = 1'b1;
    mul_longP  = 64'd63;
    step();
    mul_commit = 1'b0;
    check("t4_resp_val", 64'(bus.resp_val), 64'h1);
    check("t4_resp_p", bus.resp_p, 64'd63);

    // 5: fill to DEPTH with commits withheld
    set_ops(1, 32'd2, 32'd4);
    bus.req_val = 4'b0010;
    for (int k = 0; k < 8; k++) step();
    settle();
    check("t5_full_inflight", 64'(inflight), 64'd8);
    check("t5_full_val_op", 64'(mul_val_op), 64'd0);
    check("t5_full_req_rdy", 64'(bus.req_rdy), 64'h0);
    mul_commit = 1'b1;
    mul_longP  = 64'd8;
    settle();
    check("t5_full_commit_rdy", 64'(bus.req_rdy), 64'h0);
    step();
    mul_commit = 1'b0;
    check("t5_no_bypass", 64'(inflight), 64'd7);
    check("t5_resp_val", 64'(bus.resp_val), 64'h2);
    settle();
    check("t5_reopen_val_op", 64'(mul_val_op), 64'd1);
    check("t5_reopen_rdy", 64'(bus.req_rdy), 64'h2);
    step();
    check("t5_ninth", 64'(inflight), 64'd8);
    bus.req_val = 4'b0000;
    mul_commit  = 1'b1;
    step();
    check("t5_drain_one", 64'(inflight), 64'd7);
    bus.req_val = 4'b0010;
    step();
    check("t5_push_pop", 64'(inflight), 64'd7);
    bus.req_val = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t5_drain_resp", 64'(bus.resp_val), 64'h2);
    end
    mul_commit = 1'b0;
    check("t5_empty", 64'(inflight), 64'd0);

    // 6: orphan commit, then reset with work in flight
    mul_commit = 1'b1;
    mul_longP  = 64'd999;
    step();
    mul_commit = 1'b0;
    check("t6_orphan", 64'(err_orphan), 64'd1);
    check("t6_orphan_resp", 64'(bus.resp_val), 64'h0);
    check("t6_orphan_inflight", 64'(inflight), 64'd0);
    step();
    check("t6_orphan_sticky", 64'(err_orphan), 64'd1);
    bus.req_val = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    bus.req_val = 4'b0000;
    check("t6_inflight3", 64'(inflight), 64'd3);
    do_reset();
    check("t6_rst_inflight", 64'(inflight), 64'd0);
    check("t6_rst_err", 64'(err_orphan), 64'd0);
    check("t6_rst_resp_p", bus.resp_p, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_resp", 64'(bus.resp_val), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
